// File: rtl/dadda_pkg.sv
// rtl/dadda_pkg.sv - shared types and constants for the sequential Dadda multiplier
//
// Contents:
//   OPW, NIBW, PRODW   operand, nibble and product widths
//   state_t, ST_*      controller state encoding (IDLE, MUL, DONE)
//   step_t             2-bit nibble-pair step index
//   SHIFT_S0..S3       left shift applied to each step's partial product
//   step_shift()       maps a step index to its shift amount

package dadda_pkg;

   localparam int OPW   = 8;
   localparam int NIBW  = 4;
   localparam int PRODW = 16;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_MUL  = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   typedef logic [1:0] step_t;

   localparam logic [3:0] SHIFT_S0 = 4'd0;
   localparam logic [3:0] SHIFT_S1 = 4'd4;
   localparam logic [3:0] SHIFT_S2 = 4'd4;
   localparam logic [3:0] SHIFT_S3 = 4'd8;

   function automatic logic [3:0] step_shift(input step_t s);
      case (s)
         2'd0:    step_shift = SHIFT_S0;
         2'd1:    step_shift = SHIFT_S1;
         2'd2:    step_shift = SHIFT_S2;
         default: step_shift = SHIFT_S3;
      endcase
   endfunction

endpackage

// File: rtl/dadda_multiplier.sv
// rtl/dadda_multiplier.sv - combinational 4x4 unsigned Dadda-tree multiplier
//
// Ports:
//   A        in   4  multiplicand nibble
//   B        in   4  multiplier nibble
//   product  out  8  A * B

module dadda_multiplier
   import dadda_pkg::*;
(
   input  logic [NIBW-1:0]   A,
   input  logic [NIBW-1:0]   B,
   output logic [2*NIBW-1:0] product
);

   logic p00, p01, p02, p03;
   logic p10, p11, p12, p13;
   logic p20, p21, p22, p23;
   logic p30, p31, p32, p33;

   // Partial product pij = A[i] & B[j], weight i + j.
   assign p00 = A[0] & B[0];
   assign p01 = A[0] & B[1];
   assign p02 = A[0] & B[2];
   assign p03 = A[0] & B[3];
   assign p10 = A[1] & B[0];
   assign p11 = A[1] & B[1];
   assign p12 = A[1] & B[2];
   assign p13 = A[1] & B[3];
   assign p20 = A[2] & B[0];
   assign p21 = A[2] & B[1];
   assign p22 = A[2] & B[2];
   assign p23 = A[2] & B[3];
   assign p30 = A[3] & B[0];
   assign p31 = A[3] & B[1];
   assign p32 = A[3] & B[2];
   assign p33 = A[3] & B[3];

   // Stage 1: column heights 1,2,3,4,3,2,1 reduced to at most 3.
   logic s1_3, c1_4, s1_4, c1_5;
   assign {c1_4, s1_3} = {1'b0, p03} + {1'b0, p12};
   assign {c1_5, s1_4} = {1'b0, p13} + {1'b0, p22};

   // Stage 2: reduce every column to at most 2 bits.
   logic s2_2, c2_3, s2_3, c2_4, s2_4, c2_5, s2_5, c2_6;
   assign {c2_3, s2_2} = {1'b0, p02} + {1'b0, p11};
   assign {c2_4, s2_3} = {1'b0, s1_3} + {1'b0, p21} + {1'b0, p30};
   assign {c2_5, s2_4} = {1'b0, s1_4} + {1'b0, p31} + {1'b0, c1_4};
   assign {c2_6, s2_5} = {1'b0, p23} + {1'b0, p32} + {1'b0, c1_5};

   // Final two rows into a carry-propagate adder.
   logic [6:0] row0, row1;
   assign row0 = {p33, s2_5, s2_4, s2_3, s2_2, p01, p00};
   assign row1 = {c2_6, c2_5, c2_4, c2_3, p20, p10, 1'b0};

   assign product = {1'b0, row0} + {1'b0, row1};

endmodule

// File: rtl/dadda_mul8_seq.sv
// rtl/dadda_mul8_seq.sv - 8x8 unsigned multiplier built from one shared 4x4 Dadda tree over four cycles
//
// Ports:
//   clock        in   1   rising-edge clock
//   rst_n        in   1   asynchronous active-low reset
//   in_valid     in   1   operand pair valid
//   in_ready     out  1   high in IDLE, operands accepted on in_valid && in_ready
//   in_a         in   8   multiplicand
//   in_b         in   8   multiplier
//   out_valid    out  1   out_product holds a finished result (DONE)
//   out_ready    in   1   consumer accepts the result
//   out_product  out  16  accumulator; partial sums visible during MUL
//   busy         out  1   high whenever not IDLE

module dadda_mul8_seq
   import dadda_pkg::*;
(
   input  logic             clock,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OPW-1:0]   in_a,
   input  logic [OPW-1:0]   in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PRODW-1:0] out_product,
   output logic             busy
);

   state_t           state;
   step_t            step;
   logic [OPW-1:0]   a_lat;
   logic [OPW-1:0]   b_lat;
   logic [PRODW-1:0] acc;

   logic [NIBW-1:0]   nib_a;
   logic [NIBW-1:0]   nib_b;
   logic [2*NIBW-1:0] pp;
   logic [PRODW-1:0]  pp_shifted;

   // step[1] selects the high nibble of A, step[0] the high nibble of B:
   // 0 -> lo*lo, 1 -> lo*hi, 2 -> hi*lo, 3 -> hi*hi.
   assign nib_a = step[1] ? a_lat[OPW-1:NIBW] : a_lat[NIBW-1:0];
   assign nib_b = step[0] ? b_lat[OPW-1:NIBW] : b_lat[NIBW-1:0];

   dadda_multiplier u_mul (
      .A       (nib_a),
      .B       (nib_b),
      .product (pp)
   );

   assign pp_shifted = {{(PRODW-2*NIBW){1'b0}}, pp} << step_shift(step);

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         step  <= 2'd0;
         a_lat <= '0;
         b_lat <= '0;
         acc   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  a_lat <= in_a;
                  b_lat <= in_b;
                  acc   <= '0;
                  step  <= 2'd0;
                  state <= ST_MUL;
               end
            end
            ST_MUL: begin
               // 255*255 fits in 16 bits, so the sum never wraps.
               acc  <= acc + pp_shifted;
               step <= step + 2'd1;
               if (step == 2'd3) begin
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready    = (state == ST_IDLE);
   assign busy        = (state != ST_IDLE);
   assign out_valid   = (state == ST_DONE);
   assign out_product = acc;

endmodule

// File: doc/dadda_mul8_seq.md
# dadda_mul8_seq

Sequential 8x8 unsigned multiplier controller. It computes a 16-bit product by running one shared 4x4 `dadda_multiplier` instance over four cycles, one nibble-pair partial product per cycle, and accumulating the shifted partial products. It sits between an upstream operand source and a downstream consumer, with a valid/ready handshake on each side. It is the sequencing layer that lets the existing 4x4 Dadda datapath serve 8-bit operands without a larger tree.

## Interface
Parameters: none. Widths are fixed by the 4x4 datapath.

Ports:
- `clock`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block can accept operands; equals (state == IDLE).
- `in_a`  in  8  multiplicand, unsigned.
- `in_b`  in  8  multiplier, unsigned.
- `out_valid`  out  1  `out_product` holds a finished result.
- `out_ready`  in  1  consumer accepts the result.
- `out_product`  out  16  accumulator register.
- `busy`  out  1  high whenever state != IDLE.

## Operation
- FSM states:
  - IDLE: on `in_valid && in_ready`, latch `in_a`/`in_b`, clear acc, set step = 0, go to MUL.
  - MUL: each cycle, acc <= acc + (pp << shift[step]) and step <= step + 1. After step 3, go to DONE.
  - DONE: on `out_ready`, go to IDLE.
- Step schedule (A = latched a, B = latched b), with `pp` = the 8-bit output of the 4x4 multiplier:
  - step 0: A[3:0] x B[3:0], shift 0.
  - step 1: A[3:0] x B[7:4], shift 4.
  - step 2: A[7:4] x B[3:0], shift 4.
  - step 3: A[7:4] x B[7:4], shift 8.
- Arithmetic:
  - All values are zero-extended to 16 bits.
  - Max result is 255 x 255 = 0xFE01, so acc never overflows and no carry-out is needed.
- `in_valid` outside IDLE is ignored. Operands are not captured and no error is flagged.
- The latched operands are stable from accept until the next accept. The upstream may change `in_a`/`in_b` freely after the accept edge.
- `out_product` shows intermediate partial sums during MUL. It is only guaranteed meaningful while `out_valid` = 1.

## Timing
- Reset values (async, immediate on `rst_n` low): state IDLE, step 0, acc 0. Outputs: `out_product` 0x0000, `out_valid` 0, `busy` 0, `in_ready` 1.
- Reset mid-operation (MUL or DONE) aborts the operation. No result is produced and the block returns to IDLE with the reset values above.
- Latency:
  - Accept edge = edge 0.
  - MUL updates occur on edges 1..4.
  - `out_valid` is high from just after edge 4, i.e. 4 cycles after accept.
- `out_valid` and `out_product` stay stable while `out_ready` = 0, with no limit on the stall length.
- On the edge with `out_valid && out_ready`:
  - state becomes IDLE and `out_valid` drops.
  - `out_product` keeps its value until the next accept clears it.
- `in_ready` is never high in the same cycle as `out_valid`, so there is no same-cycle accept and retire. Minimum initiation interval is 6 cycles: accept, 4x MUL, retire.
- `out_ready` asserted before `out_valid` has no effect.

## Structure
- Shared package `dadda_pkg` holds:
  - the state enum (IDLE, MUL, DONE);
  - the 2-bit step type;
  - the constants SHIFT_S0..SHIFT_S3 = 0, 4, 4, 8;
  - widths OPW = 8, NIBW = 4, PRODW = 16.
- One sub-module: the existing `dadda_multiplier` (ports A[3:0], B[3:0], product[7:0]), instantiated exactly once. Its operand muxes are driven by step.
- Everything else (FSM, step counter, operand latch, accumulator) is flat in `dadda_mul8_seq`.

## Test plan
- 0xFF x 0xFF, `out_ready` tied 1:
  - `out_product` = 0xFE01.
  - `out_valid` rises 4 cycles after accept and lasts 1 cycle.
  - `in_ready` returns 1 the following cycle.
- 0x12 x 0x34 with `out_ready` held 0 for 3 cycles after `out_valid`:
  - product 0x03A8 is held stable.
  - `in_ready` stays 0.
  - retires on the first `out_ready` = 1 edge.
- Second operand pair 0x00 x 0xAB presented with `in_valid` high during MUL:
  - it is ignored while busy.
  - it is accepted once back in IDLE and yields 0x0000.
- `rst_n` pulsed low during step 2 of 0xF0 x 0x0F:
  - `out_valid` = 0, `busy` = 0, `in_ready` = 1, `out_product` = 0 immediately.
  - the next op 0x0F x 0xF0 yields 0x0E10.
- Exhaustive sweep of all 65536 operand pairs with random `out_ready` stalls: every result equals `in_a * in_b`.
